// File: rtl/crc5_r_pkg.sv
// Shared USB receive definitions: PID type codes, CRC5 seed, FSM encodings.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package crc5_r_pkg;

    localparam int PID_W  = 4;
    localparam int ADDR_W = 7;
    localparam int ENDP_W = 4;

    // PID type is carried in the low two bits of the PID nibble.
    localparam logic [1:0] PID_TYPE_SPECIAL   = 2'b00;
    localparam logic [1:0] PID_TYPE_TOKEN     = 2'b01;
    localparam logic [1:0] PID_TYPE_HANDSHAKE = 2'b10;
    localparam logic [1:0] PID_TYPE_DATA      = 2'b11;

    localparam logic [4:0] CRC5_SEED = 5'h1f;

    // Receive FSM state encodings.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TOK1 = 3'd1,
        ST_TOK2 = 3'd2,
        ST_OUT  = 3'd3,
        ST_DROP = 3'd4
    } rx_state_t;

    // Decoded packet as handed to the transfer layer.
    typedef struct packed {
        logic [PID_W-1:0]  pid;
        logic [ADDR_W-1:0] addr;
        logic [ENDP_W-1:0] endp;
    } rx_pkt_t;

    // A PID byte carries its own check nibble: upper half is the complement of the lower.
    function automatic logic pid_is_valid(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

    // The CRC field on the wire is the complemented residue, bit-reversed.
    function automatic logic [4:0] crc5_wire_field(input logic [4:0] c);
        return ~{c[0], c[1], c[2], c[3], c[4]};
    endfunction

endpackage

// File: rtl/crc5_r_if.sv
// Bundle of the byte stream from control_r and the decoded-packet stream.
// Latency: n/a (wires only).
// Backpressure: rx_from_ready stalls the byte stream, rx_ready stalls the packet stream.
interface crc5_r_if;
    import crc5_r_pkg::*;

    // byte stream in from control_r
    logic              rx_from_sop;
    logic              rx_from_eop;
    logic              rx_from_valid;
    logic              rx_from_ready;
    logic [7:0]        rx_from_data;

    // link-control side
    logic              rx_con_pid_en;
    logic [PID_W-1:0]  rx_con_pid;

    // decoded packet out to the transfer layer
    logic [PID_W-1:0]  rx_pid;
    logic [ADDR_W-1:0] rx_addr;
    logic [ENDP_W-1:0] rx_endp;
    logic              rx_valid;
    logic              rx_ready;

    // error pulses
    logic              rx_pid_err;
    logic              rx_crc_err;
    logic              rx_len_err;

    // Environment side: drives bytes, consumes packets.
    modport master (
        output rx_from_sop, rx_from_eop, rx_from_valid, rx_from_data, rx_ready,
        input  rx_from_ready, rx_con_pid_en, rx_con_pid,
        input  rx_pid, rx_addr, rx_endp, rx_valid,
        input  rx_pid_err, rx_crc_err, rx_len_err
    );

    // Decoder side: consumes bytes, produces packets.
    modport slave (
        input  rx_from_sop, rx_from_eop, rx_from_valid, rx_from_data, rx_ready,
        output rx_from_ready, rx_con_pid_en, rx_con_pid,
        output rx_pid, rx_addr, rx_endp, rx_valid,
        output rx_pid_err, rx_crc_err, rx_len_err
    );

endinterface

// File: rtl/crc5_r_crc5.sv
// Combinational USB CRC5 (x^5+x^2+1) over 11 bits, d[10] shifted in first.
// Latency: combinational.
// Backpressure: none.
module crc5_r_crc5 (
    input  logic [4:0]  c,
    input  logic [10:0] d,
    output logic [4:0]  c_out
);

    // Unrolled serial LFSR: one shift per data bit, feedback taps at bits 0 and 2.
    always_comb begin
        logic [4:0] w_lfsr;
        w_lfsr = c;
        for (int i = 10; i >= 0; i--) begin
            if (w_lfsr[4] ^ d[i]) begin
                w_lfsr = {w_lfsr[3:0], 1'b0} ^ 5'h05;
            end else begin
                w_lfsr = {w_lfsr[3:0], 1'b0};
            end
        end
        c_out = w_lfsr;
    end

endmodule

// File: rtl/crc5_r.sv
// USB receive packet decoder: checks PID, parses token/handshake, verifies token CRC5.
// Latency: rx_valid rises the cycle after the eop byte is accepted; error pulses one cycle after their byte.
// Backpressure: rx_from_ready drops while a decoded packet waits in OUT for rx_ready.
module crc5_r
    import crc5_r_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    crc5_r_if.slave   bus
);

    rx_state_t         r_state;
    rx_state_t         w_next;

    logic              w_from_rdy;
    logic              w_fire;

    // token work registers, filled as the token bytes arrive
    logic [ADDR_W-1:0] r_tok_addr;
    logic              r_tok_endp0;
    logic [ADDR_W-1:0] w_tok_addr_nxt;
    logic              w_tok_endp0_nxt;

    // packet presented on the output while in OUT
    rx_pkt_t           r_out;
    rx_pkt_t           w_out_nxt;
    logic              w_load_out;

    logic [PID_W-1:0]  r_con_pid;
    logic              r_con_pid_en;
    logic              w_con_en;

    // raw error conditions before prioritisation
    logic              w_pid_flag;
    logic              w_len_flag;
    logic              w_crc_flag;
    logic              r_pid_err;
    logic              r_len_err;
    logic              r_crc_err;

    logic              w_pid_byte;
    logic [10:0]       w_crc_d;
    logic [4:0]        w_crc_out;
    logic              w_crc_ok;
    logic [ENDP_W-1:0] w_tok_endp;

    assign w_from_rdy = (r_state != ST_OUT);
    assign w_fire     = bus.rx_from_valid & w_from_rdy;

    // Endpoint is complete only once the TOK2 byte is on the bus.
    assign w_tok_endp = {bus.rx_from_data[2:0], r_tok_endp0};
    assign w_crc_d    = {w_tok_endp, r_tok_addr};

    crc5_r_crc5 u_crc5 (
        .c     (CRC5_SEED),
        .d     (w_crc_d),
        .c_out (w_crc_out)
    );

    assign w_crc_ok = (bus.rx_from_data[7:3] == crc5_wire_field(w_crc_out));

    // Next-state, field capture and raw error flags for the accepted byte.
    always_comb begin
        w_next          = r_state;
        w_pid_byte      = 1'b0;
        w_pid_flag      = 1'b0;
        w_len_flag      = 1'b0;
        w_crc_flag      = 1'b0;
        w_con_en        = 1'b0;
        w_load_out      = 1'b0;
        w_out_nxt       = r_out;
        w_tok_addr_nxt  = r_tok_addr;
        w_tok_endp0_nxt = r_tok_endp0;

        case (r_state)
            ST_IDLE: begin
                // bytes outside a packet are ignored until a sop arrives
                if (w_fire && bus.rx_from_sop) begin
                    w_pid_byte = 1'b1;
                end
            end
            ST_TOK1: begin
                if (w_fire) begin
                    if (bus.rx_from_sop) begin
                        w_len_flag = 1'b1;
                        w_pid_byte = 1'b1;
                    end else begin
                        w_tok_addr_nxt  = bus.rx_from_data[6:0];
                        w_tok_endp0_nxt = bus.rx_from_data[7];
                        if (bus.rx_from_eop) begin
                            w_len_flag = 1'b1;
                            w_next     = ST_IDLE;
                        end else begin
                            w_next = ST_TOK2;
                        end
                    end
                end
            end
            ST_TOK2: begin
                if (w_fire) begin
                    if (bus.rx_from_sop) begin
                        w_len_flag = 1'b1;
                        w_pid_byte = 1'b1;
                    end else if (!bus.rx_from_eop) begin
                        w_len_flag = 1'b1;
                        w_next     = ST_DROP;
                    end else if (w_crc_ok) begin
                        w_load_out     = 1'b1;
                        w_out_nxt.pid  = r_con_pid;
                        w_out_nxt.addr = r_tok_addr;
                        w_out_nxt.endp = w_tok_endp;
                        w_next         = ST_OUT;
                    end else begin
                        w_crc_flag = 1'b1;
                        w_next     = ST_IDLE;
                    end
                end
            end
            ST_OUT: begin
                if (bus.rx_ready) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (w_fire) begin
                    if (bus.rx_from_sop) begin
                        w_len_flag = 1'b1;
                        w_pid_byte = 1'b1;
                    end else if (bus.rx_from_eop) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        // A sop byte is always a PID byte, whichever state it interrupted.
        if (w_pid_byte) begin
            if (!pid_is_valid(bus.rx_from_data)) begin
                w_pid_flag = 1'b1;
                w_next     = bus.rx_from_eop ? ST_IDLE : ST_DROP;
            end else begin
                w_con_en = 1'b1;
                case (bus.rx_from_data[1:0])
                    PID_TYPE_HANDSHAKE: begin
                        if (bus.rx_from_eop) begin
                            w_load_out     = 1'b1;
                            w_out_nxt.pid  = bus.rx_from_data[3:0];
                            w_out_nxt.addr = '0;
                            w_out_nxt.endp = '0;
                            w_next         = ST_OUT;
                        end else begin
                            w_len_flag = 1'b1;
                            w_next     = ST_DROP;
                        end
                    end
                    PID_TYPE_TOKEN: begin
                        if (bus.rx_from_eop) begin
                            w_len_flag = 1'b1;
                            w_next     = ST_IDLE;
                        end else begin
                            w_next = ST_TOK1;
                        end
                    end
                    PID_TYPE_DATA: begin
                        // data packets are not decoded here
                        w_next = bus.rx_from_eop ? ST_IDLE : ST_DROP;
                    end
                    default: begin
                        w_pid_flag = 1'b1;
                        w_next     = bus.rx_from_eop ? ST_IDLE : ST_DROP;
                    end
                endcase
            end
        end
    end

    // State register, captured fields and prioritised single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tok_addr   <= '0;
            r_tok_endp0  <= 1'b0;
            r_out        <= '0;
            r_con_pid    <= '0;
            r_con_pid_en <= 1'b0;
            r_pid_err    <= 1'b0;
            r_len_err    <= 1'b0;
            r_crc_err    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_tok_addr   <= w_tok_addr_nxt;
            r_tok_endp0  <= w_tok_endp0_nxt;
            r_con_pid_en <= w_con_en;
            if (w_con_en) begin
                r_con_pid <= bus.rx_from_data[3:0];
            end
            if (w_load_out) begin
                r_out <= w_out_nxt;
            end
            // one error per cycle: pid beats len beats crc
            r_pid_err <= w_pid_flag;
            r_len_err <= w_len_flag & ~w_pid_flag;
            r_crc_err <= w_crc_flag & ~w_pid_flag & ~w_len_flag;
        end
    end

    assign bus.rx_from_ready = w_from_rdy;
    assign bus.rx_valid      = (r_state == ST_OUT);
    assign bus.rx_pid        = r_out.pid;
    assign bus.rx_addr       = r_out.addr;
    assign bus.rx_endp       = r_out.endp;
    assign bus.rx_con_pid_en = r_con_pid_en;
    assign bus.rx_con_pid    = r_con_pid;
    assign bus.rx_pid_err    = r_pid_err;
    assign bus.rx_len_err    = r_len_err;
    assign bus.rx_crc_err    = r_crc_err;

endmodule

// File: tb/tb_crc5_r.sv
// Scoreboard bench for crc5_r: packets queued at drive time, popped on rx_valid && rx_ready.
// Latency: n/a.
// Backpressure: rx_ready is held low in one scenario to stall the decoder.
module tb_crc5_r;
    import crc5_r_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    crc5_r_if u_bus ();

    crc5_r u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] exp_q[$];

    int cnt_pid = 0, cnt_len = 0, cnt_crc = 0, cnt_en = 0;
    int cnt_pkt = 0, cnt_multi = 0, cnt_unexp = 0;
    int b_pid, b_len, b_crc, b_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: counts pulses and compares handed-off packets.
    always @(negedge clk) begin
        logic [14:0] e;
        if (u_bus.rx_pid_err)    cnt_pid++;
        if (u_bus.rx_len_err)    cnt_len++;
        if (u_bus.rx_crc_err)    cnt_crc++;
        if (u_bus.rx_con_pid_en) cnt_en++;
        if ((int'(u_bus.rx_pid_err) + int'(u_bus.rx_len_err) + int'(u_bus.rx_crc_err)) > 1)
            cnt_multi++;
        if (u_bus.rx_valid && u_bus.rx_ready) begin
            if (exp_q.size() == 0) begin
                cnt_unexp++;
            end else begin
                e = exp_q.pop_front();
                check("pkt", {u_bus.rx_pid, u_bus.rx_addr, u_bus.rx_endp}, e);
                cnt_pkt++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic s, input logic eop);
        int waitc;
        waitc = 0;
        @(negedge clk);
        u_bus.rx_from_data  = b;
        u_bus.rx_from_sop   = s;
        u_bus.rx_from_eop   = eop;
        u_bus.rx_from_valid = 1'b1;
        while (!u_bus.rx_from_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        check("byte_ready", u_bus.rx_from_ready, 1'b1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        u_bus.rx_from_valid = 1'b0;
        u_bus.rx_from_sop   = 1'b0;
        u_bus.rx_from_eop   = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({"drain_", tag}, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic snap();
        b_pid = cnt_pid; b_len = cnt_len; b_crc = cnt_crc; b_en = cnt_en;
    endtask

    task automatic expect_deltas(input string tag, input int dp, input int dl, input int dc, input int de);
        check({tag, "_pid_err"}, cnt_pid - b_pid, dp);
        check({tag, "_len_err"}, cnt_len - b_len, dl);
        check({tag, "_crc_err"}, cnt_crc - b_crc, dc);
        check({tag, "_pid_en"},  cnt_en  - b_en,  de);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        u_bus.rx_from_valid = 1'b0;
        u_bus.rx_from_sop   = 1'b0;
        u_bus.rx_from_eop   = 1'b0;
        u_bus.rx_from_data  = 8'h00;
        u_bus.rx_ready      = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_from_ready", u_bus.rx_from_ready, 1'b1);
        check("rst_valid",      u_bus.rx_valid, 1'b0);
        check("rst_fields",     {u_bus.rx_pid, u_bus.rx_addr, u_bus.rx_endp}, 15'h0);
        check("rst_con",        {u_bus.rx_con_pid_en, u_bus.rx_con_pid}, 5'h0);
        check("rst_errs",       {u_bus.rx_pid_err, u_bus.rx_len_err, u_bus.rx_crc_err}, 3'b000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ACK, single byte; valid must be up the cycle after the eop byte
        snap();
        exp_q.push_back({4'h2, 7'h00, 4'h0});
        send_byte(8'hD2, 1'b1, 1'b1);
        idle();
        check("ack_latency", u_bus.rx_valid, 1'b1);
        drain("ack");
        expect_deltas("ack", 0, 0, 0, 1);
        check("ack_con_pid", u_bus.rx_con_pid, 4'h2);

        // SETUP addr 0 endp 0
        snap();
        exp_q.push_back({4'hD, 7'h00, 4'h0});
        send_byte(8'h2D, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h10, 1'b0, 1'b1);
        idle();
        drain("setup");
        expect_deltas("setup", 0, 0, 0, 1);
        check("setup_con_pid", u_bus.rx_con_pid, 4'hD);

        // token addr 0x15 endp 0xE held while the sink stalls; a following ACK must wait
        snap();
        @(posedge clk); #1 u_bus.rx_ready = 1'b0;
        exp_q.push_back({4'h9, 7'h15, 4'hE});
        send_byte(8'h69, 1'b1, 1'b0);
        send_byte(8'h15, 1'b0, 1'b0);
        send_byte(8'hBF, 1'b0, 1'b1);
        idle();
        repeat (3) @(negedge clk);
        check("stall_valid",      u_bus.rx_valid, 1'b1);
        check("stall_from_ready", u_bus.rx_from_ready, 1'b0);
        check("stall_fields",     {u_bus.rx_pid, u_bus.rx_addr, u_bus.rx_endp}, {4'h9, 7'h15, 4'hE});
        exp_q.push_back({4'h2, 7'h00, 4'h0});
        fork
            begin
                send_byte(8'hD2, 1'b1, 1'b1);
                idle();
            end
            begin
                repeat (6) @(negedge clk);
                check("stall_no_accept", cnt_en - b_en, 1);
                check("stall_hold", {u_bus.rx_pid, u_bus.rx_addr, u_bus.rx_endp}, {4'h9, 7'h15, 4'hE});
                @(posedge clk); #1 u_bus.rx_ready = 1'b1;
            end
        join
        drain("token");
        expect_deltas("token", 0, 0, 0, 2);

        // corrupted CRC field
        snap();
        send_byte(8'h2D, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h18, 1'b0, 1'b1);
        idle();
        check("crc_no_valid", u_bus.rx_valid, 1'b0);
        drain("crc");
        expect_deltas("crc", 0, 0, 1, 1);

        // bad PID check nibble, packet dropped, then a clean ACK
        snap();
        send_byte(8'hD3, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b1);
        idle();
        drain("badpid");
        expect_deltas("badpid", 1, 0, 0, 0);
        check("badpid_con_pid", u_bus.rx_con_pid, 4'hD);
        snap();
        exp_q.push_back({4'h2, 7'h00, 4'h0});
        send_byte(8'hD2, 1'b1, 1'b1);
        idle();
        drain("ack2");
        expect_deltas("ack2", 0, 0, 0, 1);

        // token that ends after its address byte
        snap();
        send_byte(8'h2D, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b1);
        idle();
        drain("short");
        expect_deltas("short", 0, 1, 0, 1);

        // reset part-way through a token; tail byte has no sop and must vanish
        snap();
        send_byte(8'h69, 1'b1, 1'b0);
        send_byte(8'h15, 1'b0, 1'b0);
        @(negedge clk);
        u_bus.rx_from_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'hBF, 1'b0, 1'b1);
        idle();
        drain("rstmid");
        expect_deltas("rstmid", 0, 0, 0, 1);
        check("rstmid_from_ready", u_bus.rx_from_ready, 1'b1);
        check("rstmid_fields", {u_bus.rx_pid, u_bus.rx_addr, u_bus.rx_endp}, 15'h0);
        check("rstmid_con_pid", u_bus.rx_con_pid, 4'h0);

        // sop arriving in TOK1 restarts on the new PID
        snap();
        exp_q.push_back({4'h2, 7'h00, 4'h0});
        send_byte(8'h69, 1'b1, 1'b0);
        send_byte(8'hD2, 1'b1, 1'b1);
        idle();
        drain("restart");
        expect_deltas("restart", 0, 1, 0, 2);

        // length and PID error together: PID error wins
        snap();
        send_byte(8'h69, 1'b1, 1'b0);
        send_byte(8'hD3, 1'b1, 1'b1);
        idle();
        drain("prio");
        expect_deltas("prio", 1, 0, 0, 1);

        // DATA0 packet is swallowed silently
        snap();
        send_byte(8'hC3, 1'b1, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b1);
        idle();
        drain("data");
        expect_deltas("data", 0, 0, 0, 1);

        // special PID
        snap();
        send_byte(8'h3C, 1'b1, 1'b1);
        idle();
        drain("special");
        expect_deltas("special", 1, 0, 0, 1);

        // token overrunning its CRC byte
        snap();
        send_byte(8'h69, 1'b1, 1'b0);
        send_byte(8'h15, 1'b0, 1'b0);
        send_byte(8'hBF, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b1);
        idle();
        drain("long");
        expect_deltas("long", 0, 1, 0, 1);

        // handshake with trailing byte
        snap();
        send_byte(8'hD2, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b1);
        idle();
        drain("hslong");
        expect_deltas("hslong", 0, 1, 0, 1);

        check("total_pkts",  cnt_pkt, 6);
        check("unexpected",  cnt_unexp, 0);
        check("multi_error", cnt_multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crc5_r.md
CRC5_R -- requirements
Module: crc5_r

Interface
REQ-001 SHALL have clk  input  1  system clock; all logic on its rising edge.
REQ-002 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have rx_from_sop  input  1  first byte of packet, from control_r.
REQ-004 SHALL have rx_from_eop  input  1  last byte of packet, from control_r.
REQ-005 SHALL have rx_from_valid  input  1  rx_from_data/sop/eop valid.
REQ-006 SHALL have rx_from_ready  output  1  byte accepted when valid && ready.
REQ-007 SHALL have rx_from_data  input  8  received byte; bit 0 is first on the bus.
REQ-008 SHALL have rx_con_pid_en  output  1  one-cycle pulse: a valid PID byte was accepted.
REQ-009 SHALL have rx_con_pid  output  4  last valid PID, to link_control.
REQ-010 SHALL have rx_pid  output  4  decoded PID, to transfer layer.
REQ-011 SHALL have rx_addr  output  7  token address; 0 for handshake.
REQ-012 SHALL have rx_endp  output  4  token endpoint; 0 for handshake.
REQ-013 SHALL have rx_valid  output  1  decoded packet available.
REQ-014 SHALL have rx_ready  input  1  transfer layer accepts the packet when rx_valid && rx_ready.
REQ-015 SHALL have rx_pid_err, rx_crc_err, rx_len_err  outputs  1 each  one-cycle error pulses.

Function
REQ-016 SHALL implement the FSM IDLE, TOK1, TOK2, OUT, DROP; a byte moves only on rx_from_valid && rx_from_ready.
REQ-017 SHALL drive rx_from_ready=1 in IDLE/TOK1/TOK2/DROP and 0 in OUT.
REQ-018 IDLE: a byte without sop SHALL be discarded silently.
REQ-019 IDLE, sop byte with data[7:4] != ~data[3:0]: SHALL pulse rx_pid_err and go to DROP (IDLE if eop).
REQ-020 IDLE, valid PID byte: SHALL pulse rx_con_pid_en and latch rx_con_pid.
REQ-021 Handshake PID ([1:0]=10) with eop: SHALL load rx_pid, addr=0, endp=0 and go to OUT.
REQ-022 Handshake PID without eop: SHALL pulse rx_len_err and go to DROP.
REQ-023 Token PID ([1:0]=01) without eop: SHALL go to TOK1. With eop: SHALL pulse rx_len_err and stay in IDLE.
REQ-024 Data PID ([1:0]=11): SHALL be dropped silently (DROP, or IDLE if eop).
REQ-025 Special PID ([1:0]=00): SHALL pulse rx_pid_err and be dropped.
REQ-026 TOK1: SHALL latch addr=data[6:0] and endp[0]=data[7].
REQ-027 TOK1 byte with eop: SHALL pulse rx_len_err and go to IDLE; otherwise go to TOK2.
REQ-028 TOK2: SHALL latch endp[3:1]=data[2:0] and compare data[7:3] with the bit-reversed crc5 of {endp,addr}, seed 5'h1f.
REQ-029 TOK2 with eop and CRC match: SHALL go to OUT.
REQ-030 TOK2 with eop and CRC mismatch: SHALL pulse rx_crc_err, go to IDLE, and produce no output.
REQ-031 TOK2 without eop: SHALL pulse rx_len_err and go to DROP.
REQ-032 sop in TOK1/TOK2/DROP: SHALL pulse rx_len_err and process the byte as a new PID byte in the same cycle.
REQ-033 DROP: SHALL consume bytes until eop, then go to IDLE.
REQ-034 OUT: SHALL hold rx_valid=1 with stable rx_pid/addr/endp until rx_ready; on the handshake SHALL clear rx_valid and go to IDLE next cycle.
REQ-035 Latency: rx_valid SHALL rise the cycle after the eop byte handshake.
REQ-036 At most one error pulse SHALL assert per cycle, with priority pid > len > crc.

Reset
REQ-037 rst SHALL force IDLE and set all outputs to 0, except rx_from_ready=1; registered fields SHALL clear to 0.
REQ-038 rst mid-packet SHALL abort the packet without any error pulse; the remainder is discarded until the next sop.

Structure
REQ-039 PID type codes (2'b01 token, 2'b10 handshake, 2'b11 data, 2'b00 special), the CRC5 seed 5'h1f and the FSM state encodings SHALL live in the shared usb package.
REQ-040 SHALL instantiate the existing combinational crc5 sub-module (c, d[10:0], c_out) once, with d={endp,addr}.

Verification
REQ-041 ACK: 0xD2 with sop+eop -> rx_valid, rx_pid=2, addr=0, endp=0; rx_con_pid_en pulses once.
REQ-042 SETUP: 0x2D(sop), 0x00, 0x10(eop) -> rx_pid=0xD, addr=0, endp=0, no errors.
REQ-043 Token: 0x69(sop), 0x15, 0xBF(eop) -> rx_pid=9, addr=0x15, endp=0xE; second packet stalls while rx_ready=0.
REQ-044 Corrupt CRC: 0x2D, 0x00, 0x18(eop) -> rx_crc_err pulse, no rx_valid.
REQ-045 Bad PID 0xD3(sop), then 2 bytes, eop -> rx_pid_err, DROP, back to IDLE; next ACK decodes correctly.
REQ-046 Short token 0x2D, 0x00(eop) -> rx_len_err; rst asserted after the second byte of a token -> IDLE, no pulses.
